// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-master to 1-slave cbus burst arbiter; the grant is held for a whole burst.
// Define CBUS_ARB_FIXED_PRIO_EN to select fixed priority (master 0 highest) instead of round-robin.

package cbus_rr_arbiter_pkg;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam int REQ_W  = $bits(cbus_req_t);
    localparam int RESP_W = $bits(cbus_resp_t);

    localparam logic [7:0] MLEN1  = 8'd0;
    localparam logic [7:0] MLEN8  = 8'd7;
    localparam logic [7:0] MLEN16 = 8'd15;
endpackage

module cbus_rr_arbiter_lane
    import cbus_rr_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             gnt,
    input  cbus_req_t        ireq,
    input  cbus_resp_t       oresp,
    output cbus_resp_t       iresp,
    output logic [REQ_W-1:0] req_gated
);
    assign iresp     = gnt ? oresp : '0;
    assign req_gated = gnt ? ireq  : '0;

    // Dropping valid mid-burst leaves the arbiter BUSY forwarding valid=0; flag it in simulation.
    a_hold_valid: assert property (@(posedge clk) disable iff (reset) gnt |-> ireq.valid);
endmodule

module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  cbus_req_t  [NUM_MASTERS-1:0] ireqs,
    output cbus_resp_t [NUM_MASTERS-1:0] iresps,
    output cbus_req_t                    oreq,
    input  cbus_resp_t                   oresp,
    output logic                         busy,
    output logic [IDX_W-1:0]             grant_idx
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   sel_q, sel_d;
    logic [IDX_W-1:0]                   last_grant_q, last_grant_d;
    logic [NUM_MASTERS-1:0]             req_vld;
    logic [NUM_MASTERS-1:0]             gnt;
    logic [NUM_MASTERS-1:0][REQ_W-1:0]  req_gated;
    logic [REQ_W-1:0]                   oreq_bits;
    logic                               pick_vld;
    logic [IDX_W-1:0]                   pick_idx;

    assign pick_vld = |req_vld;

`ifdef CBUS_ARB_FIXED_PRIO_EN
    always_comb begin
        pick_idx = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (req_vld[i]) pick_idx = IDX_W'(i);
        end
    end
`else
    localparam logic [IDX_W:0] NM_L = (IDX_W + 1)'(NUM_MASTERS);

    logic [2*NUM_MASTERS-1:0] req_dbl;
    logic [NUM_MASTERS-1:0]   req_rot;
    logic [IDX_W:0]           start, ofs, sum;

    // Rotate the request vector so bit 0 is last_grant+1, take the lowest set bit, rotate back.
    always_comb begin
        start   = {1'b0, last_grant_q} + 1'b1;
        req_dbl = {req_vld, req_vld};
        req_rot = NUM_MASTERS'(req_dbl >> start);
        ofs     = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            if (req_rot[k]) ofs = (IDX_W + 1)'(k);
        end
        sum      = start + ofs;
        pick_idx = (sum >= NM_L) ? IDX_W'(sum - NM_L) : IDX_W'(sum);
    end
`endif

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    sel_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (oresp.ready && oresp.last) begin
                    last_grant_d = sel_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            last_grant_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
        assign req_vld[i] = ireqs[i].valid;
        assign gnt[i]     = (state_q == BUSY) && (sel_q == IDX_W'(i));

        cbus_rr_arbiter_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .gnt       (gnt[i]),
            .ireq      (ireqs[i]),
            .oresp     (oresp),
            .iresp     (iresps[i]),
            .req_gated (req_gated[i])
        );
    end

    // At most one lane is granted, so OR-ing the gated requests is the mux.
    always_comb begin
        oreq_bits = '0;
        for (int i = 0; i < NUM_MASTERS; i++) oreq_bits = oreq_bits | req_gated[i];
    end

    assign oreq      = oreq_bits;
    assign busy      = (state_q == BUSY);
    assign grant_idx = sel_q;
endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Randomized and directed bench for cbus_rr_arbiter (4 masters) against a transaction-level model.
module tb_cbus_rr_arbiter;
    import cbus_rr_arbiter_pkg::*;

    localparam int NM = 4;

    logic                clk = 1'b0;
    logic                reset;
    cbus_req_t  [NM-1:0] ireqs;
    cbus_resp_t [NM-1:0] iresps;
    cbus_req_t           oreq;
    cbus_resp_t          oresp;
    logic                busy;
    logic [1:0]          grant_idx;

    cbus_rr_arbiter #(.NUM_MASTERS(NM)) dut (
        .clk       (clk),
        .reset     (reset),
        .ireqs     (ireqs),
        .iresps    (iresps),
        .oreq      (oreq),
        .oresp     (oresp),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [299:0] got, input logic [299:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: who owns the bus, and the masters' outstanding requests.
    bit            m_busy = 0;
    int            m_sel  = 0;
    int            m_last = NM - 1;
    int            beat   = 0;
    bit [NM-1:0]   pend   = '0;
    cbus_req_t     mreq [NM];
    int            quota [NM];
    logic [63:0]   addr_cfg [NM];
    int            len_cfg = 3;
    int            wr_cfg  = -1;
    int            req_pct = 100;
    int            rdy_pct = 100;
    int            cyc     = 0;

    // Observation log, filled from the DUT outputs.
    bit            prev_busy = 0;
    int            glog [$];
    int            beats [NM];
    int            last_cyc [NM];
    int            fall_cyc;
    int            addr_cyc;
    logic [63:0]   watch_addr;

    function automatic int ref_pick(input bit [NM-1:0] v, input int last);
`ifdef CBUS_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NM; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= NM; k++) if (v[(last + k) % NM]) return (last + k) % NM;
`endif
        return -1;
    endfunction

    function automatic cbus_req_t rnd_req();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[150:0];
    endfunction

    function automatic cbus_resp_t rnd_resp();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[65:0];
    endfunction

    function automatic cbus_req_t mk_req(input int i);
        cbus_req_t r;
        r       = rnd_req();
        r.valid = 1'b1;
        r.addr  = (addr_cfg[i] != 64'd0) ? addr_cfg[i] : {32'd0, $urandom()};
        r.len   = (len_cfg >= 0) ? 8'(len_cfg) : 8'($urandom_range(7));
        if (wr_cfg >= 0) r.is_write = wr_cfg[0];
        return r;
    endfunction

    task automatic clr_log();
        glog.delete();
        for (int i = 0; i < NM; i++) begin
            beats[i]    = 0;
            last_cyc[i] = -1;
        end
        fall_cyc = -1;
        addr_cyc = -1;
    endtask

    task automatic cycle();
        cbus_req_t  exp_q;
        cbus_resp_t exp_r;
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_busy = 0; m_sel = 0; m_last = NM - 1; beat = 0;
        end else if (!m_busy) begin
            if (pend != '0) begin
                m_sel = ref_pick(pend, m_last); m_busy = 1; beat = 0;
            end
        end else if (oresp.ready) begin
            if (oresp.last) begin
                pend[m_sel] = 1'b0; m_last = m_sel; m_busy = 0; beat = 0;
            end else begin
                beat++;
                if (mreq[m_sel].is_write) begin
                    mreq[m_sel].data   = {$urandom(), $urandom()};
                    mreq[m_sel].strobe = 8'($urandom());
                end
            end
        end

        @(negedge clk);
        for (int i = 0; i < NM; i++) begin
            if (!pend[i] && quota[i] > 0 && $urandom_range(99) < req_pct) begin
                pend[i] = 1'b1; quota[i]--; mreq[i] = mk_req(i);
            end
        end
        for (int i = 0; i < NM; i++) begin
            if (pend[i]) ireqs[i] = mreq[i];
            else begin ireqs[i] = rnd_req(); ireqs[i].valid = 1'b0; end
        end
        oresp = rnd_resp();
        if (m_busy) begin
            oresp.ready = ($urandom_range(99) < rdy_pct);
            oresp.last  = oresp.ready && (beat == int'(mreq[m_sel].len));
        end
        #1;
        exp_q = m_busy ? ireqs[m_sel] : '0;
        chk("busy", busy, m_busy);
        chk("grant_idx", grant_idx, m_sel);
        chk("oreq", oreq, exp_q);
        for (int j = 0; j < NM; j++) begin
            exp_r = (m_busy && j == m_sel) ? oresp : '0;
            chk($sformatf("iresps[%0d]", j), iresps[j], exp_r);
        end

        if (busy && !prev_busy) glog.push_back(int'(grant_idx));
        if (prev_busy && !busy) fall_cyc = cyc;
        for (int i = 0; i < NM; i++) begin
            if (iresps[i].ready) beats[i]++;
            if (iresps[i].ready && iresps[i].last) last_cyc[i] = cyc;
        end
        if (oreq.valid && oreq.addr == watch_addr && addr_cyc < 0) addr_cyc = cyc;
        prev_busy = busy;
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        bit open;
        do begin
            cycle();
            n++;
            open = m_busy || (pend != '0);
            for (int i = 0; i < NM; i++) if (quota[i] > 0) open = 1'b1;
        end while (open && n < max);
        chk("idle_reached", open, 1'b0);
    endtask

    task automatic run_beats(input int m, input int nb, input int max);
        int n = 0;
        while (beats[m] < nb && n < max) begin cycle(); n++; end
        chk($sformatf("beats%0d_reached", m), beats[m], nb);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ireqs = '0;
        oresp = '0;
        watch_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < NM; i++) begin
            quota[i] = 0; addr_cfg[i] = 64'd0; mreq[i] = '0;
        end
        clr_log();

        // T1: reset held with m0 requesting; grant shows one cycle after release.
        quota[0] = 1;
        repeat (3) begin
            cycle();
            chk("t1_rst_valid", oreq.valid, 1'b0);
            chk("t1_rst_iresps", iresps, '0);
        end
        reset = 1'b0;
        cycle();
        chk("t1_valid_after_rel", oreq.valid, 1'b1);
        chk("t1_grant_after_rel", grant_idx, 2'd0);
        run_idle(200);

        // T2: 16-beat read from m0.
        clr_log();
        addr_cfg[0] = 64'h8000_0000; len_cfg = int'(MLEN16); wr_cfg = 0; quota[0] = 1;
        run_idle(200);
        chk("t2_m0_beats", beats[0], 16);
        chk("t2_m1_beats", beats[1], 0);
        chk("t2_busy_fall", fall_cyc, last_cyc[0] + 1);

        // T3: m0 and m1 continuously requesting single-beat bursts.
        do_reset(2);
        clr_log();
        addr_cfg[0] = 64'd0; len_cfg = int'(MLEN1); wr_cfg = -1;
        quota[0] = 6; quota[1] = 6;
        run_idle(400);
        chk("t3_grants", glog.size(), 12);
        for (int k = 0; k < 12; k++) begin
`ifdef CBUS_ARB_FIXED_PRIO_EN
            chk($sformatf("t3_grant%0d", k), (k < glog.size()) ? glog[k] : 99, (k < 6) ? 0 : 1);
`else
            chk($sformatf("t3_grant%0d", k), (k < glog.size()) ? glog[k] : 99, k % 2);
`endif
        end

        // T4: all four contend after m2 was last granted.
        do_reset(2);
        quota[2] = 1;
        run_idle(100);
        clr_log();
        for (int i = 0; i < NM; i++) quota[i] = 1;
        run_idle(200);
        chk("t4_grants", glog.size(), 4);
        for (int k = 0; k < 4; k++) begin
`ifdef CBUS_ARB_FIXED_PRIO_EN
            chk($sformatf("t4_grant%0d", k), (k < glog.size()) ? glog[k] : 99, k);
`else
            chk($sformatf("t4_grant%0d", k), (k < glog.size()) ? glog[k] : 99, (k + 3) % 4);
`endif
        end

        // T5: m1 arrives mid-burst and must wait for m0's last beat.
        clr_log();
        len_cfg = int'(MLEN16);
        addr_cfg[0] = 64'h8000_1000; addr_cfg[1] = 64'h9000_0000; watch_addr = 64'h9000_0000;
        quota[0] = 1;
        run_beats(0, 5, 100);
        quota[1] = 1;
        run_idle(300);
        chk("t5_m1_beats", beats[1], 16);
        chk("t5_addr_switch", addr_cyc, last_cyc[0] + 2);

        // T6: reset at beat 3 of an 8-beat burst; waiting m1 wins afterwards.
        do_reset(2);
        clr_log();
        addr_cfg[0] = 64'd0; addr_cfg[1] = 64'd0;
        len_cfg = int'(MLEN8); quota[0] = 1; quota[1] = 1;
        run_beats(0, 3, 100);
        reset = 1'b1; pend[0] = 1'b0; quota[0] = 0;
        cycle();
        chk("t6_valid_drop", oreq.valid, 1'b0);
        chk("t6_busy_drop", busy, 1'b0);
        reset = 1'b0;
        glog.delete();
        run_idle(200);
        chk("t6_first_grant", (glog.size() > 0) ? glog[0] : 99, 1);

        // Random traffic: mixed lengths, reads/writes, bridge back-pressure.
        do_reset(2);
        len_cfg = -1; wr_cfg = -1; req_pct = 30; rdy_pct = 60;
        for (int i = 0; i < NM; i++) quota[i] = 25;
        run_idle(20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
